// File: rtl/multi_channel_magic_scoreboard.sv
// Multi-channel in-line magic-packet scoreboard for a shared linked-list FIFO.
// Tracks one magic packet per channel, checks in-order delivery and data
// integrity, and flags environment protocol violations. Observes only.
//
// Optional build macro: SB_REARM_EN. When defined, DONE returns to IDLE on
// the next cycle so each channel can check repeated magic packets. When not
// defined, DONE is terminal until reset.
//
// Ports:
//   clk          clock, all state on posedge
//   rst          asynchronous active-low reset
//   push/pop     FIFO push/pop observed this cycle
//   push_sel     channel being pushed
//   pop_sel      channel being popped
//   data_in      push data
//   data_out     FIFO read data, valid combinationally in a pop cycle
//   start        per-channel request to mark the current push as magic
//   data_out_vld current pop is a tracked magic packet (combinational)
//   prop_signal  low only when a magic pop carries the wrong data (combinational)
//   done         per-channel: magic packet has been checked
//   err          sticky data mismatch
//   env_err      sticky environment protocol violation
module multi_channel_magic_scoreboard #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned NUM_FIFOS = 2,
    parameter int unsigned SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [SEL_WIDTH-1:0] push_sel,
    input  logic [SEL_WIDTH-1:0] pop_sel,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    input  logic [NUM_FIFOS-1:0] start,
    output logic                 data_out_vld,
    output logic                 prop_signal,
    output logic [NUM_FIFOS-1:0] done,
    output logic                 err,
    output logic                 env_err
);

    localparam int unsigned TOT_WIDTH = $clog2(NUM_FIFOS * DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] occ   [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] ahead [NUM_FIFOS];
    logic [WIDTH-1:0]     magic [NUM_FIFOS];

    logic [NUM_FIFOS-1:0] push_c;
    logic [NUM_FIFOS-1:0] pop_c;
    logic [NUM_FIFOS-1:0] occ_underflow;
    logic [TOT_WIDTH-1:0] total;
    logic                 push_sel_bad;
    logic                 pop_sel_bad;
    logic                 env_viol;

    // Per-channel decode, total occupancy and protocol checks
    always_comb begin
        push_c        = '0;
        pop_c         = '0;
        occ_underflow = '0;
        total         = '0;
        for (int c = 0; c < NUM_FIFOS; c++) begin
            push_c[c]        = push && (push_sel == SEL_WIDTH'(c));
            pop_c[c]         = pop && (pop_sel == SEL_WIDTH'(c));
            occ_underflow[c] = pop_c[c] && (occ[c] == '0);
            total            = total + TOT_WIDTH'(occ[c]);
        end
        push_sel_bad = 32'(push_sel) >= NUM_FIFOS;
        pop_sel_bad  = 32'(pop_sel) >= NUM_FIFOS;
        env_viol     = (|occ_underflow)
                     || (push && !pop && (total == TOT_WIDTH'(DEPTH)))
                     || push_sel_bad || pop_sel_bad;
    end

    // Magic-pop detection and data comparison on the popped channel
    always_comb begin
        data_out_vld = 1'b0;
        prop_signal  = 1'b1;
        if (pop && !pop_sel_bad) begin
            data_out_vld = (state[pop_sel] == ST_TRACK) && (ahead[pop_sel] == '0);
            prop_signal  = !data_out_vld || (data_out == magic[pop_sel]);
        end
    end

    always_comb begin
        done = '0;
        for (int c = 0; c < NUM_FIFOS; c++) begin
            done[c] = (state[c] == ST_DONE);
        end
    end

    // Shadow occupancy, per-channel tracking FSMs and sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err     <= 1'b0;
            env_err <= 1'b0;
            for (int c = 0; c < NUM_FIFOS; c++) begin
                state[c] <= ST_IDLE;
                occ[c]   <= '0;
                ahead[c] <= '0;
                magic[c] <= '0;
            end
        end else begin
            err     <= err || !prop_signal;
            env_err <= env_err || env_viol;
            for (int c = 0; c < NUM_FIFOS; c++) begin
                // Saturating occupancy; push+pop on one channel cancels out
                case ({push_c[c], pop_c[c]})
                    2'b10: if (occ[c] != CNT_WIDTH'(DEPTH)) occ[c] <= occ[c] + CNT_WIDTH'(1);
                    2'b01: if (occ[c] != '0) occ[c] <= occ[c] - CNT_WIDTH'(1);
                    default: occ[c] <= occ[c];
                endcase

                case (state[c])
                    ST_IDLE: begin
                        if (start[c] && push_c[c]) begin
                            magic[c] <= data_in;
                            // A same-cycle pop removes one entry ahead of the magic one
                            ahead[c] <= (pop_c[c] && (occ[c] != '0)) ? occ[c] - CNT_WIDTH'(1) : occ[c];
                            state[c] <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (pop_c[c]) begin
                            if (ahead[c] != '0) begin
                                ahead[c] <= ahead[c] - CNT_WIDTH'(1);
                            end else begin
                                state[c] <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
`ifdef SB_REARM_EN
                        state[c] <= ST_IDLE;
`else
                        state[c] <= ST_DONE;
`endif
                    end
                    default: state[c] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_magic_scoreboard.sv
// Self-checking bench for multi_channel_magic_scoreboard (NUM_FIFOS=2, DEPTH=4).
// Reference model: the shared FIFO as one queue of tagged entries.
module tb_multi_channel_magic_scoreboard;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned NUM_FIFOS = 2;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       push_sel;
    logic       pop_sel;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic [1:0] start;
    logic       data_out_vld;
    logic       prop_signal;
    logic [1:0] done;
    logic       err;
    logic       env_err;

    int checks;
    int passes;

    multi_channel_magic_scoreboard #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_FIFOS(NUM_FIFOS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .push_sel    (push_sel),
        .pop_sel     (pop_sel),
        .data_in     (data_in),
        .data_out    (data_out),
        .start       (start),
        .data_out_vld(data_out_vld),
        .prop_signal (prop_signal),
        .done        (done),
        .err         (err),
        .env_err     (env_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ch;
        logic       mg;
        logic [3:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_pending [2];
    bit   m_checked [2];
    bit   m_pulse   [2];
    bit   m_err;

    function automatic int head_idx(input int c);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].ch == 1'(c)) return i;
        end
        return -1;
    endfunction

    function automatic int count(input int c);
        int n;
        n = 0;
        foreach (q[i]) if (q[i].ch == 1'(c)) n++;
        return n;
    endfunction

    function automatic logic [1:0] exp_done();
        logic [1:0] r;
        for (int c = 0; c < 2; c++) begin
`ifdef SB_REARM_EN
            r[c] = m_pulse[c];
`else
            r[c] = m_checked[c];
`endif
        end
        return r;
    endfunction

    task automatic cyc(input int pu, input int po, input int ps, input int pps,
                       input int di, input int dout, input int st);
        @(negedge clk);
        push     = 1'(pu);
        pop      = 1'(po);
        push_sel = 1'(ps);
        pop_sel  = 1'(pps);
        data_in  = 4'(di);
        data_out = 4'(dout);
        start    = 2'(st);
        #1;
    endtask

    // Advance one clock edge and apply the same cycle to the model
    task automatic tick();
        int  hi;
        bit  can [2];
        bit  nxt [2];
        ent_t e;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
`ifdef SB_REARM_EN
            can[c] = !m_pending[c] && !m_pulse[c];
`else
            can[c] = !m_pending[c] && !m_checked[c];
`endif
            nxt[c] = 1'b0;
        end
        if (pop) begin
            hi = head_idx(int'(pop_sel));
            if (hi >= 0) begin
                if (q[hi].mg) begin
                    if (data_out !== q[hi].d) m_err = 1'b1;
                    m_pending[pop_sel] = 1'b0;
                    m_checked[pop_sel] = 1'b1;
                    nxt[pop_sel]       = 1'b1;
                end
                q.delete(hi);
            end
        end
        if (push && count(int'(push_sel)) < DEPTH) begin
            e.ch = push_sel;
            e.d  = data_in;
            e.mg = start[push_sel] && can[push_sel];
            if (e.mg) m_pending[push_sel] = 1'b1;
            q.push_back(e);
        end
        m_pulse = nxt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; push_sel = 1'b0; pop_sel = 1'b0;
        data_in = '0; data_out = '0; start = '0;
        q.delete();
        m_pending = '{default: 1'b0};
        m_checked = '{default: 1'b0};
        m_pulse   = '{default: 1'b0};
        m_err     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; push = 1'b1; pop = 1'b1; push_sel = 1'b0; pop_sel = 1'b0;
        start = 2'b11; data_in = 4'h5; data_out = 4'h6;
        #1;
        checks++; if (done !== 2'b00) $display("FAIL reset_done got=%b exp=00", done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passes++;
        checks++; if (env_err !== 1'b0) $display("FAIL reset_env_err got=%b exp=0", env_err); else passes++;
        checks++; if (data_out_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", data_out_vld); else passes++;
        checks++; if (prop_signal !== 1'b1) $display("FAIL reset_prop got=%b exp=1", prop_signal); else passes++;
        @(posedge clk); #1;
        checks++; if (data_out_vld !== 1'b0) $display("FAIL reset_hold_vld got=%b exp=0", data_out_vld); else passes++;
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1, 0, 0, 0, 3, 0, 0); tick();
        cyc(1, 0, 0, 0, 5, 0, 1); tick();
        cyc(0, 1, 0, 0, 0, 3, 0);
        checks++; if (data_out_vld !== 1'b0) $display("FAIL basic_first_pop_vld got=%b exp=0", data_out_vld); else passes++;
        tick();
        cyc(0, 1, 0, 0, 0, 5, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL basic_magic_vld got=%b exp=1", data_out_vld); else passes++;
        checks++; if (prop_signal !== 1'b1) $display("FAIL basic_magic_prop got=%b exp=1", prop_signal); else passes++;
        checks++; if (done !== 2'b00) $display("FAIL basic_done_early got=%b exp=00", done); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (done !== 2'b01) $display("FAIL basic_done got=%b exp=01", done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL basic_err got=%b exp=0", err); else passes++;
        tick();
    endtask

    task automatic test_mismatch();
        do_reset();
        cyc(1, 0, 0, 0, 3, 0, 0); tick();
        cyc(1, 0, 0, 0, 5, 0, 1); tick();
        cyc(0, 1, 0, 0, 0, 3, 0); tick();
        cyc(0, 1, 0, 0, 0, 6, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL mism_vld got=%b exp=1", data_out_vld); else passes++;
        checks++; if (prop_signal !== 1'b0) $display("FAIL mism_prop got=%b exp=0", prop_signal); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL mism_err_early got=%b exp=0", err); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) $display("FAIL mism_err got=%b exp=1", err); else passes++;
        checks++; if (prop_signal !== 1'b1) $display("FAIL mism_prop_idle got=%b exp=1", prop_signal); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) $display("FAIL mism_err_sticky got=%b exp=1", err); else passes++;
        tick();
    endtask

    task automatic test_interleaved();
        do_reset();
        cyc(1, 0, 0, 0, 1, 0, 0); tick();
        cyc(1, 0, 1, 0, 9, 0, 2); tick();
        cyc(1, 0, 0, 0, 2, 0, 1); tick();
        cyc(0, 1, 0, 1, 0, 9, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL inter_ch1_vld got=%b exp=1", data_out_vld); else passes++;
        checks++; if (prop_signal !== 1'b1) $display("FAIL inter_ch1_prop got=%b exp=1", prop_signal); else passes++;
        tick();
        cyc(0, 1, 0, 0, 0, 1, 0);
        checks++; if (data_out_vld !== 1'b0) $display("FAIL inter_ch0_first_vld got=%b exp=0", data_out_vld); else passes++;
        checks++; if (done !== 2'b10) $display("FAIL inter_done_ch1 got=%b exp=10", done); else passes++;
        tick();
        cyc(0, 1, 0, 0, 0, 2, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL inter_ch0_vld got=%b exp=1", data_out_vld); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef SB_REARM_EN
        checks++; if (done !== 2'b01) $display("FAIL inter_done got=%b exp=01", done); else passes++;
`else
        checks++; if (done !== 2'b11) $display("FAIL inter_done got=%b exp=11", done); else passes++;
`endif
        checks++; if (err !== 1'b0) $display("FAIL inter_err got=%b exp=0", err); else passes++;
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        cyc(1, 0, 0, 0, 1, 0, 0); tick();
        cyc(1, 0, 0, 0, 2, 0, 0); tick();
        cyc(1, 1, 0, 0, 7, 1, 1);
        checks++; if (data_out_vld !== 1'b0) $display("FAIL same_pushpop_vld got=%b exp=0", data_out_vld); else passes++;
        tick();
        cyc(0, 1, 0, 0, 0, 2, 0);
        checks++; if (data_out_vld !== 1'b0) $display("FAIL same_pop1_vld got=%b exp=0", data_out_vld); else passes++;
        tick();
        cyc(0, 1, 0, 0, 0, 7, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL same_pop2_vld got=%b exp=1", data_out_vld); else passes++;
        checks++; if (prop_signal !== 1'b1) $display("FAIL same_pop2_prop got=%b exp=1", prop_signal); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (done !== 2'b01) $display("FAIL same_done got=%b exp=01", done); else passes++;
        checks++; if (env_err !== 1'b0) $display("FAIL same_env_err got=%b exp=0", env_err); else passes++;
        tick();
    endtask

    task automatic test_env_err();
        do_reset();
        cyc(0, 1, 0, 1, 0, 0, 0);
        checks++; if (env_err !== 1'b0) $display("FAIL env_underflow_early got=%b exp=0", env_err); else passes++;
        tick();
        cyc(1, 0, 1, 0, 10, 0, 2);
        checks++; if (env_err !== 1'b1) $display("FAIL env_underflow got=%b exp=1", env_err); else passes++;
        tick();
        // Occupancy of ch1 must have stayed at zero, so this pop is the magic one
        cyc(0, 1, 0, 1, 0, 10, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL env_occ_sat_vld got=%b exp=1", data_out_vld); else passes++;
        tick();

        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, i % 2, 0, i, 0, 0); tick();
        end
        cyc(1, 1, 1, 0, 4, 0, 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (env_err !== 1'b0) $display("FAIL env_full_pushpop got=%b exp=0", env_err); else passes++;
        tick();
        cyc(1, 0, 0, 0, 5, 0, 0);
        checks++; if (env_err !== 1'b0) $display("FAIL env_overflow_early got=%b exp=0", env_err); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (env_err !== 1'b1) $display("FAIL env_overflow got=%b exp=1", env_err); else passes++;
        tick();
    endtask

    task automatic test_rearm();
        do_reset();
        cyc(1, 0, 0, 0, 4, 0, 1); tick();
        cyc(0, 1, 0, 0, 0, 4, 0);
        checks++; if (data_out_vld !== 1'b1) $display("FAIL rearm_first_vld got=%b exp=1", data_out_vld); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (done !== 2'b01) $display("FAIL rearm_first_done got=%b exp=01", done); else passes++;
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef SB_REARM_EN
        checks++; if (done !== 2'b00) $display("FAIL rearm_pulse_end got=%b exp=00", done); else passes++;
`else
        checks++; if (done !== 2'b01) $display("FAIL rearm_done_hold got=%b exp=01", done); else passes++;
`endif
        tick();
        cyc(1, 0, 0, 0, 8, 0, 1); tick();
        cyc(0, 1, 0, 0, 0, 8, 0);
`ifdef SB_REARM_EN
        checks++; if (data_out_vld !== 1'b1) $display("FAIL rearm_second_vld got=%b exp=1", data_out_vld); else passes++;
`else
        checks++; if (data_out_vld !== 1'b0) $display("FAIL rearm_second_vld got=%b exp=0", data_out_vld); else passes++;
`endif
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (done !== 2'b01) $display("FAIL rearm_second_done got=%b exp=01", done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL rearm_err got=%b exp=0", err); else passes++;
        tick();
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int n = 0; n < 150; n++) begin
                int pu, po, ps, pps, di, dout, st, hi;
                bit exp_vld, exp_prop;
                po  = int'($urandom_range(0, 1));
                pps = int'($urandom_range(0, 1));
                if (po != 0 && count(pps) == 0) po = 0;
                pu = int'($urandom_range(0, 1));
                ps = int'($urandom_range(0, 1));
                if (pu != 0 && po == 0 && q.size() >= DEPTH) pu = 0;
                di = int'($urandom_range(0, 15));
                st = int'($urandom_range(0, 3)) & int'($urandom_range(0, 3));
                dout = int'($urandom_range(0, 15));
                exp_vld  = 1'b0;
                exp_prop = 1'b1;
                if (po != 0) begin
                    hi   = head_idx(pps);
                    dout = int'(q[hi].d);
                    if (q[hi].mg && (ep % 2 == 1) && $urandom_range(0, 1) == 1)
                        dout = dout ^ int'($urandom_range(1, 15));
                    exp_vld  = q[hi].mg;
                    exp_prop = !exp_vld || (4'(dout) == q[hi].d);
                end
                cyc(pu, po, ps, pps, di, dout, st);
                checks++; if (data_out_vld !== exp_vld) $display("FAIL rnd_vld ep=%0d n=%0d got=%b exp=%b", ep, n, data_out_vld, exp_vld); else passes++;
                checks++; if (prop_signal !== exp_prop) $display("FAIL rnd_prop ep=%0d n=%0d got=%b exp=%b", ep, n, prop_signal, exp_prop); else passes++;
                checks++; if (done !== exp_done()) $display("FAIL rnd_done ep=%0d n=%0d got=%b exp=%b", ep, n, done, exp_done()); else passes++;
                checks++; if (err !== m_err) $display("FAIL rnd_err ep=%0d n=%0d got=%b exp=%b", ep, n, err, m_err); else passes++;
                checks++; if (env_err !== 1'b0) $display("FAIL rnd_env_err ep=%0d n=%0d got=%b exp=0", ep, n, env_err); else passes++;
                tick();
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; push_sel = 1'b0; pop_sel = 1'b0;
        data_in = '0; data_out = '0; start = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_interleaved();
        test_same_cycle();
        test_env_err();
        test_rearm();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_magic_scoreboard.md
Name: multi_channel_magic_scoreboard

Overview:
Parametrised successor to the single-channel in-line scoreboard used in the shared linked-list FIFO proofs. It tracks one "magic packet" independently in every FIFO channel of a NUM_FIFOS-channel shared FIFO and checks that each packet emerges in order with its data intact. It also flags environment protocol violations. It sits beside linked_list_fifo in proof/sim tops, observes the FIFO's push/pop interface, and drives no FIFO inputs.

Parameters:
WIDTH, 4, data width
DEPTH, 2, total shared FIFO entries (all channels together)
NUM_FIFOS, 2, number of logical FIFO channels
SEL_WIDTH, max(1,$clog2(NUM_FIFOS)), channel select width
CNT_WIDTH, $clog2(DEPTH+1), occupancy/position counter width

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-low reset
push  input  1  FIFO push observed this cycle
pop  input  1  FIFO pop observed this cycle
push_sel  input  SEL_WIDTH  channel being pushed
pop_sel  input  SEL_WIDTH  channel being popped
data_in  input  WIDTH  push data
data_out  input  WIDTH  FIFO read data, valid combinationally in a pop cycle
start  input  NUM_FIFOS  per-channel request to mark the current push as magic
data_out_vld  output  1  current pop is a tracked magic packet
prop_signal  output  1  0 only when data_out_vld and data_out differs from the magic data
done  output  NUM_FIFOS  channel's magic packet has been checked
err  output  1  sticky: some magic packet mismatched
env_err  output  1  sticky: environment protocol violation

Behaviour:
- Reset (rst=0, async): all per-channel counters = 0, all FSMs = IDLE, magic regs = 0, done = 0, err = 0, env_err = 0.
- Shadow occupancy per channel c: occ[c] += push_c - pop_c every cycle in all FSM states, where push_c = push & (push_sel==c) and pop_c = pop & (pop_sel==c). Total occupancy is the sum over channels.
- Per-channel FSM:
  - IDLE: on start[c] & push_c, capture magic[c] <= data_in and ahead[c] <= occ[c] - pop_c, then go to TRACK. start[c] without push_c is ignored.
  - TRACK: on pop_c with ahead[c]!=0, ahead[c] decrements. On pop_c with ahead[c]==0, this pop is the magic packet: compare and go to DONE. Further start[c] is ignored.
  - DONE: done[c]=1. Behaviour after DONE depends on SB_REARM_EN.
- data_out_vld is combinational: pop & FSM[pop_sel]==TRACK & ahead[pop_sel]==0.
- prop_signal is combinational: !data_out_vld | (data_out == magic[pop_sel]).
- err is set on the clock edge after a cycle with prop_signal=0 and held until reset.
- env_err is set on the clock edge after any of these, and held until reset:
  - pop_c with occ[c]==0;
  - push with total occupancy==DEPTH and no simultaneous pop;
  - push_sel >= NUM_FIFOS or pop_sel >= NUM_FIFOS.
- Simultaneous push and pop on the same channel: both are applied; a magic push in that cycle accounts for the pop via ahead = occ - 1.
- Simultaneous events on different channels are fully independent.
- Counters saturate: never wrap below 0 or above DEPTH, even under env_err.
- Reset mid-TRACK aborts tracking with no err.
- Magic push into an empty channel gives ahead=0, so the next pop_c is the checked pop.

Optional Feature:
SB_REARM_EN
- Defined: DONE returns to IDLE on the next cycle (done[c] is a 1-cycle pulse), so repeated magic packets per channel are checked. err remains sticky.
- Not defined: DONE is terminal until reset; done[c] stays high.

Test Plan:
- NUM_FIFOS=2, DEPTH=4. ch0: push A=3, then push 5 with start[0]=1, pop, pop → second pop data_out_vld=1, data_out=5, prop_signal=1, done[0]=1 next cycle, err=0.
- Same sequence, but bench drives data_out=6 on the magic pop → prop_signal=0 that cycle, err=1 from next cycle onward.
- Interleaved: ch1 magic 9 pushed at occ[1]=0, ch0 magic 2 pushed behind one entry, pops alternate ch1/ch0 → ch1 vld on its first pop, ch0 vld on its second pop; both done, err=0.
- Same-cycle push ch0 (start[0]=1, data 7) + pop ch0 with occ[0]=2 → ahead=1; second following pop ch0 is vld with data 7.
- Pop ch1 while occ[1]=0 → env_err=1 next cycle, occ[1] stays 0. Push at total occupancy 4 → env_err=1.
- With SB_REARM_EN: two consecutive magic packets 4 then 8 on ch0 → two done[0] pulses; without the macro the second start[0] is ignored and done[0] stays 1.
